// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared encodings, buffer entry type and PC helpers for the
// instruction fetch controller. Optional feature macro: FETCH_PERF_EN.
// The macro block mirrors the shared define.v. Each name is guarded, so a
// define.v compiled earlier keeps its own values.
`ifndef RomEnable
`define RomEnable 1'b1
`endif
`ifndef RomDisable
`define RomDisable 1'b0
`endif
`ifndef Zero
`define Zero 32'h0000_0000
`endif
`ifndef FetchIdle
`define FetchIdle 2'b00
`endif
`ifndef FetchRun
`define FetchRun 2'b01
`endif
`ifndef FetchFull
`define FetchFull 2'b10
`endif

package fetch_ctrl_pkg;

  // One fetch-buffer entry: the fetch address and the word read from ROM.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Force a target onto a word boundary (the low two bits are dropped).
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

  // Sequential successor, wrapping modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] addr);
    return addr + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: ROM port, redirect request and decode handshake of the
// fetch controller. master = fetch_ctrl side, slave = environment side.
// Optional feature macro: FETCH_PERF_EN (does not affect this bundle).
interface fetch_ctrl_if;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  modport master (
    output rom_ce, rom_addr, id_valid, id_inst, id_pc,
    input  rom_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  rom_ce, rom_addr, id_valid, id_inst, id_pc,
    output rom_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_buf.sv
// fetch_buf: BUF_DEPTH-entry FIFO of {pc, inst} with flush. The head is
// presented combinationally and reads as zero when the FIFO is empty.
// Optional feature macro: FETCH_PERF_EN (not used here).
module fetch_buf
  import fetch_ctrl_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push_i,
  input  logic                             pop_i,
  input  logic                             flush_i,
  input  fetch_entry_t                     wr_entry_i,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   count_o,
  output fetch_entry_t                     head_o
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  fetch_entry_t     mem_q [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is accepted only when the head leaves in the
  // same cycle. Depth is a power of two, so the pointers wrap naturally.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != DEPTH_C) || do_pop);

  // Next pointers and occupancy; flush empties the FIFO regardless of push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage. Entries are not reset because count_q masks stale data.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wr_entry_i;
  end

  assign count_o = count_q;
  assign head_o  = (count_q == '0) ? {`Zero, `Zero} : mem_q[rd_ptr_q];
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequential instruction fetch into a small buffer feeding
// decode, with redirect flush and zero-bubble push/pop.
// Optional feature macro: FETCH_PERF_EN adds perf_fetch_cnt/perf_stall_cnt.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_ctrl_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetch_cnt,
  output logic [31:0]  perf_stall_cnt
`endif
);
  localparam logic [1:0] ST_IDLE = `FetchIdle;
  localparam logic [1:0] ST_RUN  = `FetchRun;
  localparam logic [1:0] ST_FULL = `FetchFull;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] buf_count, count_after;
  fetch_entry_t     buf_head, wr_entry;
  logic             id_valid_w, pop, push, redirect;

  assign redirect   = bus.redirect_valid;
  assign id_valid_w = (buf_count != '0);
  assign pop        = id_valid_w && bus.id_ready;
  // Fetch only outside IDLE, never during a redirect, and only when there is
  // room now or a slot is freed by the pop in this same cycle.
  assign push       = (state_q != ST_IDLE) && !redirect &&
                      ((buf_count < DEPTH_C) || pop);
  assign wr_entry   = '{pc: pc_q, inst: bus.rom_data};
  assign count_after = redirect ? '0 : (buf_count + CNT_W'(push) - CNT_W'(pop));

  fetch_buf #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .pop_i      (pop),
    .flush_i    (redirect),
    .wr_entry_i (wr_entry),
    .count_o    (buf_count),
    .head_o     (buf_head)
  );

  // Next PC: redirect target (aligned) beats sequential advance.
  always_comb begin
    pc_d = pc_q;
    if (redirect)  pc_d = align_pc(bus.redirect_pc);
    else if (push) pc_d = next_pc(pc_q);
  end

  // FSM: IDLE lasts one cycle after reset; FULL tracks a full buffer after the edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN:  if (count_after == DEPTH_C) state_d = ST_FULL;
      ST_FULL: if (count_after != DEPTH_C) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // PC and state registers; reset overrides redirect, push and pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= ST_IDLE;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign bus.rom_ce   = push ? `RomEnable : `RomDisable;
  assign bus.rom_addr = pc_q;
  assign bus.id_valid = id_valid_w;
  assign bus.id_inst  = buf_head.inst;
  assign bus.id_pc    = buf_head.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_stall_q;

  // Counters of pushes and of cycles spent full with nothing leaving.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (push)                      perf_fetch_q <= perf_fetch_q + 32'd1;
      if ((state_q == ST_FULL) && !pop) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized ready/redirect/reset
// traffic. A scoreboard queue holds the expected program-order stream and a
// negedge monitor compares every accepted instruction against it.
`timescale 1ns/1ps
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
  localparam int          SB_LEN  = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_ctrl_if bus ();
  fetch_ctrl_if wbus ();

  // ROM contents: a fixed scramble of the address.
  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
  endfunction

  assign bus.rom_data        = rom_fn(bus.rom_addr);
  assign wbus.rom_data       = rom_fn(wbus.rom_addr);
  assign wbus.redirect_valid = 1'b0;
  assign wbus.redirect_pc    = 32'h0;
  assign wbus.id_ready       = 1'b1;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, w_perf_fetch, w_perf_stall;
`endif

  fetch_ctrl #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  fetch_ctrl #(.RESET_PC(WRAP_PC), .BUF_DEPTH(DEPTH)) wdut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (wbus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (w_perf_fetch),
    .perf_stall_cnt (w_perf_stall)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  fetch_entry_t exp_q[$];
  fetch_entry_t mon_e;
  logic         started   = 1'b0;
  logic         hold_prev = 1'b0;
  logic [31:0]  hold_pc, hold_inst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Expected stream: consecutive words starting at the aligned target.
  task automatic sb_reload(input logic [31:0] start);
    logic [31:0] a;
    fetch_entry_t e;
    exp_q.delete();
    a = start & 32'hFFFF_FFFC;
    for (int i = 0; i < SB_LEN; i++) begin
      e.pc   = a;
      e.inst = rom_fn(a);
      exp_q.push_back(e);
      a = a + 32'd4;
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    nxt();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    sb_reload(RST_PC);
    repeat (cycles) nxt();
    rst_n = 1'b1;
  endtask

  // Monitor: scoreboard on accepted instructions, plus per-cycle invariants.
  always @(negedge clk) begin
    if (started && rst_n) begin
      check("addr_align", bus.rom_addr & 32'h3, 32'h0);
      if (!bus.id_valid) begin
        check("empty_pc", bus.id_pc, 32'h0);
        check("empty_inst", bus.id_inst, 32'h0);
      end
      if (hold_prev) begin
        check("hold_pc", bus.id_pc, hold_pc);
        check("hold_inst", bus.id_inst, hold_inst);
      end
      if (bus.id_valid && bus.id_ready && !bus.redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_underflow: got pc %08h expected no entry", bus.id_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_pc", bus.id_pc, mon_e.pc);
          check("sb_inst", bus.id_inst, mon_e.inst);
          $display("txn pc=%08h inst=%08h", bus.id_pc, bus.id_inst);
        end
      end
      hold_prev = bus.id_valid && !bus.id_ready && !bus.redirect_valid;
      hold_pc   = bus.id_pc;
      hold_inst = bus.id_inst;
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] wrap_exp [3];
    int pushes;
    int since;
    int r;
    logic full_seen;

    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;

    // Reset: 3 cycles low, IDLE cycle, then fetch 0,4,8 with id_pc one cycle behind.
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b1;
    sb_reload(RST_PC);
    repeat (3) nxt();
    started = 1'b1;
    rst_n   = 1'b1;
    smp();
    check("rst_rom_ce", 32'(bus.rom_ce), 32'd0);
    check("rst_rom_addr", bus.rom_addr, RST_PC);
    check("rst_id_valid", 32'(bus.id_valid), 32'd0);
    check("wrap_rst_rom_ce", 32'(wbus.rom_ce), 32'd0);
    for (int k = 0; k < 4; k++) begin
      nxt();
      smp();
      check("run_rom_ce", 32'(bus.rom_ce), 32'd1);
      check("run_rom_addr", bus.rom_addr, 32'(4 * k));
      if (k >= 1) begin
        check("run_id_valid", 32'(bus.id_valid), 32'd1);
        check("run_id_pc", bus.id_pc, 32'(4 * (k - 1)));
        check("wrap_id_pc", wbus.id_pc, wrap_exp[k-1]);
      end
    end

    // Backpressure: decode never ready, exactly DEPTH pushes then fetch stops.
    bus.id_ready = 1'b0;
    do_reset(2);
    pushes = 0;
    for (int k = 0; k < 6; k++) begin
      smp();
      if (bus.rom_ce) pushes++;
      nxt();
    end
    smp();
    check("bp_pushes", 32'(pushes), 32'(DEPTH));
    check("bp_rom_ce", 32'(bus.rom_ce), 32'd0);
    check("bp_rom_addr", bus.rom_addr, 32'(4 * DEPTH));
    check("bp_id_pc", bus.id_pc, 32'h0);
    nxt();
    bus.id_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      smp();
      if (k == 0) begin
        check("bp_resume_ce", 32'(bus.rom_ce), 32'd1);
        check("bp_resume_addr", bus.rom_addr, 32'(4 * DEPTH));
      end
      check("bp_order_valid", 32'(bus.id_valid), 32'd1);
      check("bp_order_pc", bus.id_pc, 32'(4 * k));
      nxt();
    end

    // Redirect while the buffer is full.
    bus.id_ready = 1'b0;
    full_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      smp();
      if (!bus.rom_ce) begin
        full_seen = 1'b1;
        break;
      end
      nxt();
    end
    check("redir_fill_done", 32'(full_seen), 32'd1);
    nxt();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0013;
    sb_reload(32'h0000_0013);
    smp();
    check("redir_cycle_valid", 32'(bus.id_valid), 32'd1);
    check("redir_cycle_ce", 32'(bus.rom_ce), 32'd0);
    nxt();
    bus.redirect_valid = 1'b0;
    smp();
    check("redir_next_valid", 32'(bus.id_valid), 32'd0);
    check("redir_next_addr", bus.rom_addr, 32'h0000_0010);
    check("redir_next_ce", 32'(bus.rom_ce), 32'd1);
    nxt();
    smp();
    check("redir_first_valid", 32'(bus.id_valid), 32'd1);
    check("redir_first_pc", bus.id_pc, 32'h0000_0010);
    check("redir_first_inst", bus.id_inst, rom_fn(32'h0000_0010));

    // Redirect in the same cycle as a pop: the popped entry is dropped.
    nxt();
    bus.id_ready = 1'b1;
    repeat (3) nxt();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0400;
    sb_reload(32'h0000_0400);
    smp();
    check("rp_pop_present", 32'(bus.id_valid), 32'd1);
    nxt();
    bus.redirect_valid = 1'b0;
    smp();
    check("rp_next_valid", 32'(bus.id_valid), 32'd0);
    nxt();
    smp();
    check("rp_first_pc", bus.id_pc, 32'h0000_0400);

    // Randomized traffic: ready, redirects (any target) and occasional reset.
    since = 0;
    for (int i = 0; i < 3000; i++) begin
      nxt();
      rst_n = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.id_ready = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 999);
      if (r < 4) begin
        rst_n = 1'b0;
        sb_reload(RST_PC);
        since = 0;
      end else if (r < 70 || since > 200) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = $urandom;
        sb_reload(bus.redirect_pc);
        since = 0;
      end else begin
        since++;
      end
    end
    nxt();
    rst_n = 1'b1;
    bus.redirect_valid = 1'b0;

`ifdef FETCH_PERF_EN
    // 10 free-run cycles, then 5 cycles with decode stalled.
    bus.id_ready = 1'b1;
    do_reset(2);
    repeat (9) nxt();
    nxt();
    bus.id_ready = 1'b0;
    repeat (5) nxt();
    smp();
    check("perf_stall_cnt", perf_stall_cnt, 32'(5 - (DEPTH - 1)));
    check("perf_fetch_cnt", perf_fetch_cnt, 32'(9 + (DEPTH - 1)));
    nxt();
`endif

    nxt();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, fetch-buffer entries (legal values 2 or 4).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port rom_ce  output  1  instruction ROM chip enable (`RomEnable/`RomDisable).
REQ-006 SHALL have port rom_addr  output  32  ROM byte address, word-aligned.
REQ-007 SHALL have port rom_data  input  32  ROM read word, combinational from rom_addr in the same cycle.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-009 SHALL have port redirect_pc  input  32  redirect target.
REQ-010 SHALL have port id_ready  input  1  decode stage accepts an instruction.
REQ-011 SHALL have port id_valid  output  1  id_inst/id_pc hold a valid entry.
REQ-012 SHALL have port id_inst  output  32  instruction at buffer head.
REQ-013 SHALL have port id_pc  output  32  address of id_inst.

Function
REQ-014 SHALL keep PC register pc; rom_addr = pc at all times.
REQ-015 SHALL implement FSM IDLE -> RUN -> FULL: IDLE only in the first cycle after reset release, then RUN; RUN -> FULL when the buffer is full after the edge; FULL -> RUN when an entry is popped with no simultaneous capture.
REQ-016 SHALL drive rom_ce=1 only when state != IDLE, redirect_valid=0, and (count < BUF_DEPTH or pop this cycle).
REQ-017 SHALL, when rom_ce=1, push {pc, rom_data} into the buffer at the edge and set pc <= pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-018 SHALL define pop = id_valid & id_ready; the head advances at the edge.
REQ-019 SHALL assert id_valid whenever count > 0; id_inst/id_pc are the head entry, and are 0 when empty.
REQ-020 SHALL have zero-bubble throughput: simultaneous push and pop leave count unchanged, one instruction per cycle.
REQ-021 SHALL give redirect_valid priority over push and pop: at the edge, flush the buffer (count=0), set pc <= {redirect_pc[31:2],2'b00}, with no capture that cycle.
REQ-022 SHALL present the first redirected instruction on id_valid two cycles after the redirect cycle (fetch next cycle, visible after that edge).
REQ-023 SHALL hold id_inst/id_pc stable while id_valid=1 and id_ready=0.
REQ-024 SHALL treat redirect_valid during IDLE as loading pc; state still goes to RUN.

Reset
REQ-025 SHALL, on rising clk with rst_n=0, set pc=RESET_PC, count=0, state=IDLE, giving rom_ce=0, rom_addr=RESET_PC, id_valid=0, id_inst=0, id_pc=0.
REQ-026 SHALL have reset win over redirect, push and pop when asserted mid-operation; buffered entries are discarded.

Configuration
REQ-027 SHALL honour macro FETCH_PERF_EN: when defined, add outputs perf_fetch_cnt[31:0] (incremented per push) and perf_stall_cnt[31:0] (incremented per cycle in FULL without pop), both reset to 0 and wrapping.
REQ-028 SHALL, when FETCH_PERF_EN is undefined, omit both ports and counters with otherwise identical behaviour.

Structure
REQ-029 SHALL take `RomEnable, `RomDisable, `Zero and the FSM state encodings (`FetchIdle, `FetchRun, `FetchFull) from the shared define.v.
REQ-030 SHALL instantiate one sub-module fetch_buf: a BUF_DEPTH-entry 64-bit FIFO with push, pop, flush, count, and head outputs.

Verification
REQ-031 SHALL cover reset: rst_n=0 for 3 cycles, then high. Cycle 1 rom_ce=0. From cycle 2, rom_addr=0,4,8 and id_pc=0 appears one cycle later.
REQ-032 SHALL cover backpressure: id_ready=0 from start. Exactly BUF_DEPTH pushes (pc=0,4), then rom_ce=0 and rom_addr held at 8. id_ready=1 resumes one instruction per cycle in order 0,4,8.
REQ-033 SHALL cover redirect: redirect_pc=32'h0000_0013 while buffer holds 2 entries. Next cycle id_valid=0 and rom_addr=32'h10. Following cycle id_pc=32'h10.
REQ-034 SHALL cover redirect and pop in the same cycle: the popped entry is dropped, and no entry from the old stream ever appears.
REQ-035 SHALL cover wrap: RESET_PC=32'hFFFF_FFF8 gives fetch order FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 SHALL cover FETCH_PERF_EN: 10 free-run cycles then id_ready=0 for 5 cycles gives perf_stall_cnt = 5 - (cycles to fill) and perf_fetch_cnt equal to the number of pushes.
